// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the memory-stage load/store unit.
//   mem_op_e    - funct3 encodings of the supported load/store widths
//   lsu_state_e - access sequencer states (IDLE -> BUSY -> DONE)
//   WORD_BYTES  - byte lanes on the data-memory bus
package lsu_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for mem_lsu.
//   Store side (current EX inputs):
//     op_i, addr_lo_i, is_store_i, store_data_i -> be_o, wdata_o,
//     misaligned_o, illegal_o
//   Load side (latched access):
//     ld_op_i, ld_addr_lo_i, rdata_i -> ld_data_o (aligned, extended)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            op_i,
    input  logic [1:0]            addr_lo_i,
    input  logic                  is_store_i,
    input  logic [31:0]           store_data_i,
    input  logic [2:0]            ld_op_i,
    input  logic [1:0]            ld_addr_lo_i,
    input  logic [31:0]           rdata_i,
    output logic [WORD_BYTES-1:0] be_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           ld_data_o,
    output logic                  misaligned_o,
    output logic                  illegal_o
);

    logic [31:0] shifted;

    // Legality, alignment, byte enables and lane-replicated store data.
    always_comb begin
        be_o         = '0;
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (op_i)
            MEM_B, MEM_BU: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{store_data_i[7:0]}};
                illegal_o = is_store_i && (op_i == MEM_BU);
            end
            MEM_H, MEM_HU: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
                illegal_o    = is_store_i && (op_i == MEM_HU);
            end
            MEM_W: begin
                be_o         = '1;
                wdata_o      = store_data_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign shifted = rdata_i >> {ld_addr_lo_i, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (ld_op_i)
            MEM_B:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  ld_data_o = {24'h0, shifted[7:0]};
            MEM_H:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  ld_data_o = {16'h0, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with req/ack data bus.
//   clk_i, reset_i (sync, active-high)
//   valid_i, addr_i, store_data_i, mem_op_i, mem_wren_i, mem_rden_i : EX-stage access
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o     : bus request
//   dmem_ack_i, dmem_rdata_i                                         : bus response
//   stall_o  : hold upstream while an access is being accepted/in flight
//   done_o   : one-cycle completion pulse; ld_data_o valid with it
//   err_o    : one-cycle misaligned / illegal-op (or timeout) pulse
// Optional macro LSU_TIMEOUT_EN: ack watchdog of TIMEOUT_CYCLES BUSY cycles.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  mem_op_i,
    input  logic        mem_wren_i,
    input  logic        mem_rden_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] ld_data_o,
    output logic        err_o
);

    // The watchdog counter is 16 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_lsu: TIMEOUT_CYCLES must be in 1..65535");
    end

    lsu_state_e state_q, state_d;

    logic [31:0]           addr_q;
    logic [1:0]            lo_q;
    logic [31:0]           wdata_q;
    logic [WORD_BYTES-1:0] be_q;
    logic                  we_q;
    logic [2:0]            op_q;
    logic [31:0]           ld_data_q;
    logic                  err_q;

    logic                  acc;
    logic                  accept;
    logic                  reject;
    logic                  timeout;
    logic [WORD_BYTES-1:0] be_c;
    logic [31:0]           wdata_c;
    logic [31:0]           ld_ext;
    logic                  misaligned;
    logic                  illegal;

    lsu_align u_align (
        .op_i         (mem_op_i),
        .addr_lo_i    (addr_i[1:0]),
        .is_store_i   (mem_wren_i),
        .store_data_i (store_data_i),
        .ld_op_i      (op_q),
        .ld_addr_lo_i (lo_q),
        .rdata_i      (dmem_rdata_i),
        .be_o         (be_c),
        .wdata_o      (wdata_c),
        .ld_data_o    (ld_ext),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    // Store wins when both wren and rden are set: is_store follows wren.
    assign acc    = valid_i & (mem_wren_i | mem_rden_i);
    assign accept = (state_q == IDLE) & acc & ~misaligned & ~illegal;
    assign reject = (state_q == IDLE) & acc & (misaligned | illegal);

`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt_q;

    // Ack has priority: timeout only fires in a BUSY cycle without ack.
    assign timeout = (state_q == BUSY) & ~dmem_ack_i
                   & (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == BUSY) && !dmem_ack_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (dmem_ack_i || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE:    stall_o = accept;
            BUSY: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Access registers: captured at accept and held through BUSY.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
        end else if (accept) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            lo_q    <= addr_i[1:0];
            wdata_q <= wdata_c;
            be_q    <= be_c;
            we_q    <= mem_wren_i;
            op_q    <= mem_op_i;
        end
    end

    // Load result and error pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ld_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= reject | timeout;
            if ((state_q == BUSY) && dmem_ack_i && !we_q) begin
                ld_data_q <= ld_ext;
            end else if (timeout) begin
                ld_data_q <= '0;
            end
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign ld_data_o    = ld_data_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [2:0]  op;
    logic        wren;
    logic        rden;
    logic        req;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic [31:0] ld;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_ld = 32'h0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .valid_i      (valid),
        .addr_i       (addr),
        .store_data_i (sdata),
        .mem_op_i     (op),
        .mem_wren_i   (wren),
        .mem_rden_i   (rden),
        .dmem_req_o   (req),
        .dmem_we_o    (we),
        .dmem_addr_o  (daddr),
        .dmem_wdata_o (wdata),
        .dmem_be_o    (be),
        .dmem_ack_i   (ack),
        .dmem_rdata_i (rdata),
        .stall_o      (stall),
        .done_o       (done),
        .ld_data_o    (ld),
        .err_o        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        ack   = 1'b0;
    endtask

    // One legal access with ack on the k-th BUSY cycle.
    task automatic access(input string tag, input logic [2:0] o, input logic is_st,
                          input logic [31:0] a, input logic [31:0] d, input int k,
                          input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        valid = 1'b1; op = o; wren = is_st; rden = ~is_st; addr = a; sdata = d;
        #1;
        chk({tag, ".accept_stall"}, 32'(stall), 32'd1);
        chk({tag, ".accept_req"}, 32'(req), 32'd0);
        for (int c = 1; c <= k; c++) begin
            tick();
            ack   = (c == k);
            rdata = (c == k) ? rd : 32'hx;
            #1;
            chk({tag, ".busy_req"}, 32'(req), 32'd1);
            chk({tag, ".busy_stall"}, 32'(stall), 32'd1);
            chk({tag, ".busy_done"}, 32'(done), 32'd0);
            if (c == k) begin
                chk({tag, ".addr"}, daddr, {a[31:2], 2'b00});
                chk({tag, ".be"}, 32'(be), 32'(exp_be));
                chk({tag, ".we"}, 32'(we), 32'(is_st));
                if (is_st) chk({tag, ".wdata"}, wdata, exp_wd);
            end
        end
        tick();
        idle_inputs();
        #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        chk({tag, ".done_req"}, 32'(req), 32'd0);
        chk({tag, ".done_err"}, 32'(err), 32'd0);
        chk({tag, ".ld_data"}, ld, exp_ld);
        last_ld = exp_ld;
        tick();
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    // A request that must be refused with an error pulse.
    task automatic bad_access(input string tag, input logic [2:0] o, input logic is_st,
                              input logic [31:0] a);
        valid = 1'b1; op = o; wren = is_st; rden = ~is_st; addr = a; sdata = 32'h55AA55AA;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk({tag, ".err"}, 32'(err), 32'd1);
        chk({tag, ".req"}, 32'(req), 32'd0);
        tick();
        chk({tag, ".err_drop"}, 32'(err), 32'd0);
        chk({tag, ".req_after"}, 32'(req), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        addr = '0; sdata = '0; op = '0; rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst.req", 32'(req), 32'd0);
        chk("rst.we", 32'(we), 32'd0);
        chk("rst.be", 32'(be), 32'd0);
        chk("rst.addr", daddr, 32'd0);
        chk("rst.wdata", wdata, 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ld", ld, 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);

        access("SW",  3'b010, 1'b1, 32'h100, 32'hDEADBEEF, 2, 32'h0,      4'b1111, 32'hDEADBEEF, 32'h0);
        access("LB",  3'b000, 1'b0, 32'h203, 32'h0,       1, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80);
        access("LBU", 3'b100, 1'b0, 32'h203, 32'h0,       2, 32'h80112233, 4'b1000, 32'h0, 32'h00000080);
        access("LH",  3'b001, 1'b0, 32'h202, 32'h0,       1, 32'h9ABC0000, 4'b1100, 32'h0, 32'hFFFF9ABC);
        access("SH",  3'b001, 1'b1, 32'h202, 32'h00001234, 1, 32'h0,     4'b1100, 32'h12341234, 32'hFFFF9ABC);
        access("LHU", 3'b101, 1'b0, 32'h102, 32'h0,       3, 32'h80017777, 4'b1100, 32'h0, 32'h00008001);
        access("LW",  3'b010, 1'b0, 32'h104, 32'h0,       1, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);
        access("SB",  3'b000, 1'b1, 32'h301, 32'h000000A5, 1, 32'h0,     4'b0010, 32'hA5A5A5A5, 32'hCAFEF00D);

        bad_access("LW_mis", 3'b010, 1'b0, 32'h101);
        bad_access("LH_mis", 3'b001, 1'b0, 32'h203);
        bad_access("op011",  3'b011, 1'b0, 32'h100);
        bad_access("SBU",    3'b100, 1'b1, 32'h100);

        // Valid but not a memory op, then a stray ack while idle.
        valid = 1'b1; op = 3'b010; addr = 32'h100;
        #1;
        chk("nomem.stall", 32'(stall), 32'd0);
        tick();
        chk("nomem.req", 32'(req), 32'd0);
        chk("nomem.err", 32'(err), 32'd0);
        valid = 1'b0; ack = 1'b1; rdata = 32'h12345678;
        tick();
        ack = 1'b0;
        #1;
        chk("stray_ack.done", 32'(done), 32'd0);
        chk("stray_ack.ld", ld, last_ld);

        // Reset while BUSY.
        valid = 1'b1; op = 3'b010; rden = 1'b1; addr = 32'h300;
        tick();
        chk("rstbusy.req", 32'(req), 32'd1);
        reset = 1'b1;
        idle_inputs();
        tick();
        #1;
        chk("rstbusy.req_after", 32'(req), 32'd0);
        chk("rstbusy.stall", 32'(stall), 32'd0);
        chk("rstbusy.done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        chk("rstbusy.done_later", 32'(done), 32'd0);
        last_ld = 32'h0;
        access("SB2", 3'b000, 1'b1, 32'h301, 32'h000000A5, 1, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);

`ifdef LSU_TIMEOUT_EN
        valid = 1'b1; op = 3'b010; rden = 1'b1; addr = 32'h400;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) idle_inputs();
            #1;
            chk("to.busy_req", 32'(req), 32'd1);
        end
        tick();
        chk("to.req_drop", 32'(req), 32'd0);
        chk("to.done", 32'(done), 32'd1);
        chk("to.err", 32'(err), 32'd1);
        chk("to.ld", ld, 32'd0);
        tick();
        chk("to.done_drop", 32'(done), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit; sits directly downstream of the EX pipeline register and ALU.
- Consumes the EX-stage address (ALU result), store data (rs2) and LSU controls (mem_op, mem_wren, mem_rden).
- Drives a req/ack data-memory bus, stalls the pipeline while an access is outstanding, and returns the aligned, extended load data for writeback.

Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  instruction in this stage is live (not a bubble)
- addr_i  in  32  byte address from ALU
- store_data_i  in  32  rs2 data
- mem_op_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_wren_i  in  1  store
- mem_rden_i  in  1  load
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  write enable
- dmem_addr_o  out  32  word address {addr[31:2],2'b00}
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_ack_i  in  1  access complete; rdata valid same cycle
- dmem_rdata_i  in  32  read word
- stall_o  out  1  freeze upstream stages and this stage's inputs
- done_o  out  1  one-cycle completion pulse
- ld_data_o  out  32  extended load result, valid while done_o=1
- err_o  out  1  one-cycle misaligned or illegal-op pulse

Behaviour:
- Reset values: state IDLE; dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, done_o=0, err_o=0, ld_data_o=0. stall_o=0 unless IDLE accept conditions hold.
- Access request: acc = valid_i & (mem_wren_i | mem_rden_i). If both are set, the access is a store.
- Misalignment: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal op: mem_op 011, 110, 111; also any op other than B/H/W for a store.
- FSM IDLE:
  - acc & legal & aligned: stall_o=1 combinationally; latch addr, wdata, be, we, op; go BUSY.
  - acc & (misaligned | illegal): err_o=1 next cycle; no bus request; no stall; stay IDLE.
- FSM BUSY:
  - dmem_req_o=1; all dmem_* outputs held stable; stall_o=1.
  - On dmem_ack_i: capture ld_data (loads only; stores leave ld_data_o unchanged); go DONE.
- FSM DONE:
  - done_o=1, stall_o=0; the pipeline advances at this edge.
  - Unconditionally return to IDLE; new inputs are never evaluated in DONE.
- Latency: accept at cycle T; req from T+1; ack at T+k (k≥1); done_o at T+k+1. Minimum 3 cycles per access.
- Byte enables: B: 0001<<addr[1:0]; H: 0011<<addr[1:0]; W: 1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extract: shift dmem_rdata_i right by 8*addr[1:0], then truncate. B/H sign-extend; BU/HU zero-extend; W unchanged.
- valid_i=0 or a non-memory op: no action, stall_o=0.
- Reset mid-access (BUSY or DONE): IDLE next edge; dmem_req_o drops; no done_o.
- dmem_ack_i while not in BUSY: ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop req, go DONE with err_o=1 and ld_data_o=0.
  - If ack arrives in the same cycle as the timeout, ack wins.
- Not defined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - mem_op_e enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - lsu_state_e enum (IDLE, BUSY, DONE).
  - Constant WORD_BYTES=4.
- Sub-module lsu_align (combinational): store be/wdata generation, load extract/extend, misalign/illegal detect. mem_lsu holds the FSM and registers.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ack after 2 cycles -> req for 2 cycles with addr 0x100, be=1111, we=1; stall high 3 cycles; done_o 1 cycle.
- LB addr=0x203, rdata=0x80112233 -> be=1000; ld_data_o=0xFFFFFF80. LBU same -> 0x00000080.
- LH addr=0x202, rdata=0x9ABC0000 -> ld_data_o=0xFFFF9ABC. SH addr=0x202, data=0x1234 -> be=1100, wdata=0x12341234.
- LW addr=0x101 -> err_o pulse, dmem_req_o never asserted, stall_o=0. mem_op=011 -> err_o.
- Reset asserted during BUSY -> next cycle req=0, stall=0, no done_o. A later SB still completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack held low -> req drops after 4 BUSY cycles; done_o=1, err_o=1, ld_data_o=0.
